// File: rtl/issue_execute_fifo_if.sv
// Issue-to-execute FIFO handshake: pack type package and bundle interface.
// master: issue/execute side; slave: the FIFO. Ports: data_in, push, pop, flush -> FIFO; full, count, data_out, data_out_valid <- FIFO.
package issue_execute_pkg;

    typedef struct packed {
        logic [5:0]  rob_id;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } issue_execute_pack_t;

endpackage

interface issue_execute_fifo_if #(
    parameter int DEPTH = 8
);
    import issue_execute_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    issue_execute_pack_t data_in;
    logic                push;
    logic                full;
    logic [CW-1:0]       count;
    issue_execute_pack_t data_out;
    logic                data_out_valid;
    logic                pop;
    logic                flush;

    modport master (
        output data_in, push, pop, flush,
        input  full, count, data_out, data_out_valid
    );

    modport slave (
        input  data_in, push, pop, flush,
        output full, count, data_out, data_out_valid
    );

endinterface

// File: rtl/issue_execute_fifo.sv
// Single-clock FIFO of issue_execute_pack_t between issue and an execute unit.
// Ports: clk, rst (sync, active-high), fifo (slave modport). Optional same-cycle bypass: ISSUE_EXECUTE_FIFO_BYPASS_EN.
module issue_execute_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    issue_execute_fifo_if.slave  fifo
);
    import issue_execute_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       count_w;
    issue_execute_pack_t mem_q [DEPTH];
    issue_execute_pack_t head_w;

    logic full_w;
    logic stored_w;
    logic head_valid_w;
    logic pop_ok_w;
    logic push_ok_w;
    logic wr_en_w;
    logic rd_adv_w;

    assign count_w  = wptr_q - rptr_q;
    assign full_w   = (count_w == PW'(DEPTH));
    assign stored_w = (count_w != '0);

`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
    logic byp_w;

    // Empty FIFO: present the incoming pack straight away.
    assign byp_w        = !stored_w && fifo.push && !fifo.flush;
    assign head_valid_w = stored_w || byp_w;
    assign head_w       = byp_w ? fifo.data_in : mem_q[rptr_q[AW-1:0]];
`else
    assign head_valid_w = stored_w;
    assign head_w       = mem_q[rptr_q[AW-1:0]];
`endif

    assign pop_ok_w  = fifo.pop && head_valid_w && !fifo.flush;
    assign push_ok_w = fifo.push && !fifo.flush && (!full_w || pop_ok_w);

`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
    // A bypassed pack consumed in the same cycle is never stored.
    assign wr_en_w  = push_ok_w && !(byp_w && pop_ok_w);
    assign rd_adv_w = pop_ok_w && !byp_w;
`else
    assign wr_en_w  = push_ok_w;
    assign rd_adv_w = pop_ok_w;
`endif

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (fifo.flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (rd_adv_w) begin
                rptr_d = rptr_q + PW'(1);
            end
            if (wr_en_w) begin
                wptr_d = wptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    // When full with a same-cycle pop, the tail slot equals the head slot
    // being released, so the write is safe.
    always_ff @(posedge clk) begin
        if (wr_en_w && !rst) begin
            mem_q[wptr_q[AW-1:0]] <= fifo.data_in;
        end
    end

    assign fifo.full           = full_w;
    assign fifo.count          = count_w;
    assign fifo.data_out       = head_w;
    assign fifo.data_out_valid = head_valid_w;

endmodule

// File: tb/tb_issue_execute_fifo.sv
// Self-checking bench for issue_execute_fifo: vector table plus hand sequences,
// with a queue scoreboard checking pack order at the head.
module tb_issue_execute_fifo;
    import issue_execute_pkg::*;

    localparam int DEPTH = 8;
`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit       push;
        bit       pop;
        bit       flush;
        bit [5:0] rob;
        int       ecount;
        bit       efull;
        bit       evalid;
    } vec_t;

    logic clk;
    logic rst;

    issue_execute_fifo_if #(.DEPTH(DEPTH)) bus ();

    issue_execute_fifo #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    issue_execute_pack_t sb[$];
    vec_t tbl[18];

    function automatic issue_execute_pack_t mk(input bit [5:0] rob);
        issue_execute_pack_t p;
        p.rob_id  = rob;
        p.op      = rob[3:0] ^ 4'h5;
        p.rd      = {rob[4:0]} + 5'd1;
        p.rs1_val = 32'hA5A5_0000 | {26'h0, rob};
        p.rs2_val = 32'h1234_0000 + {26'h0, rob} * 32'd3;
        return p;
    endfunction

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle; model acceptance, check head before the edge,
    // then check count/full/valid after it.
    task automatic step(input bit p, input bit q, input bit f,
                        input bit [5:0] rob, input int ecount,
                        input bit efull, input bit evalid,
                        input string tag);
        int mc;
        bit byp, mvalid, mfull, pop_ok, push_ok;
        issue_execute_pack_t exp_head;
        bus.push    = p;
        bus.pop     = q;
        bus.flush   = f;
        bus.data_in = mk(rob);
        mc      = sb.size();
        byp     = BYP && (mc == 0) && p && !f;
        mvalid  = (mc != 0) || byp;
        mfull   = (mc == DEPTH);
        pop_ok  = q && mvalid && !f;
        push_ok = p && !f && (!mfull || pop_ok);
        #1;
        chk({tag, ".pre_valid"}, 96'(bus.data_out_valid), 96'(mvalid));
        if (mvalid) begin
            exp_head = byp ? mk(rob) : sb[0];
            chk({tag, ".head"}, 96'(bus.data_out), 96'(exp_head));
        end
        if (f) begin
            sb.delete();
        end else begin
            if (pop_ok && !byp) void'(sb.pop_front());
            if (push_ok && !(byp && pop_ok)) sb.push_back(mk(rob));
        end
        @(posedge clk);
        #1;
        chk({tag, ".count"}, 96'(bus.count), 96'(ecount));
        chk({tag, ".full"}, 96'(bus.full), 96'(efull));
        chk({tag, ".valid"}, 96'(bus.data_out_valid), 96'(evalid));
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 6'(i), i + 1, (i == 7), 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 6'd9, 8, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++)
            tbl[9 + i] = '{1'b0, 1'b1, 1'b0, 6'd0, 7 - i, 1'b0, (i != 7)};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 6'd0, 0, 1'b0, 1'b0};

        rst         = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.data_in = mk(6'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.count", 96'(bus.count), 96'd0);
        chk("reset.full", 96'(bus.full), 96'd0);
        chk("reset.valid", 96'(bus.data_out_valid), 96'd0);

        // Fill, overflow drop, drain, pop-on-empty.
        for (int i = 0; i < 18; i++)
            step(tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].rob,
                 tbl[i].ecount, tbl[i].efull, tbl[i].evalid,
                 $sformatf("tbl%0d", i));

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++)
            step(1, 0, 0, 6'(i), i + 1, (i == 7), 1, "refill");
        step(1, 1, 0, 6'h20, 8, 1, 1, "full_pushpop");
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 6'd0, 7 - i, 0, (i != 7), "drain20");
        chk("drain20.sb_empty", 96'(sb.size()), 96'd0);

        // Pop while empty, then push visible as head.
        step(0, 1, 0, 6'd0, 0, 0, 0, "empty_pop");
        step(1, 0, 0, 6'd3, 1, 0, 1, "push3");
        step(0, 1, 0, 6'd0, 0, 0, 0, "pop3");

        // Flush with push and pop at count 5.
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 6'(10 + i), i + 1, 0, 1, "pre_flush");
        step(1, 1, 1, 6'h2A, 0, 0, 0, "flush");
        step(1, 0, 0, 6'h11, 1, 0, 1, "post_flush");
        step(0, 1, 0, 6'd0, 0, 0, 0, "post_flush_pop");

        // Wrap-around with three outstanding.
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 6'(i), i + 1, 0, 1, "wrap_fill");
        for (int i = 3; i < 20; i++)
            step(1, 1, 0, 6'(i), 3, 0, 1, "wrap");
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 6'd0, 2 - i, 0, (i != 2), "wrap_drain");

        // Empty push: bypass shows it now, otherwise next cycle.
        step(1, 0, 0, 6'd7, 1, 0, 1, "byp_push");
        step(0, 1, 0, 6'd0, 0, 0, 0, "byp_pop");
        step(1, 1, 0, 6'd7, BYP ? 0 : 1, 0, !BYP, "byp_pushpop");
        if (sb.size() != 0)
            step(0, 1, 0, 6'd0, 0, 0, 0, "byp_cleanup");

        // Reset mid-stream.
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 6'(30 + i), i + 1, 0, 1, "pre_rst");
        rst       = 1'b1;
        bus.push  = 1'b1;
        bus.pop   = 1'b1;
        bus.flush = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        sb.delete();
        chk("rst_mid.count", 96'(bus.count), 96'd0);
        chk("rst_mid.full", 96'(bus.full), 96'd0);
        chk("rst_mid.valid", 96'(bus.data_out_valid), 96'd0);
        step(1, 0, 0, 6'd5, 1, 0, 1, "after_rst");
        step(0, 1, 0, 6'd0, 0, 0, 0, "after_rst_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
